// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multicycle RV32I-subset core on one unified req/ready memory port.
// Optional macro RV_ILLEGAL_HALT_EN: illegal instructions stop the core in HALT instead of acting as NOPs.
module riscv_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAdr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic        Retire,
    output logic        Halted
);
    // state    | meaning
    // FETCH    | read instruction at PC, PC += 4
    // DECODE   | load A/B, speculative branch target, dispatch
    // MEMADR   | effective address for lw/sw
    // MEMREAD  | data read, result into Data
    // MEMWB    | rd <- Data
    // MEMWRITE | store B to ALUOut
    // EXECR    | ALUOut <- A op B
    // EXECI    | ALUOut <- A op imm
    // ALUWB    | rd <- ALUOut
    // BRANCH   | beq/bne resolve
    // JAL      | link and jump
    // LUI      | rd <- upper immediate
    // HALT     | stopped on illegal instruction until reset
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam int         AW     = (NREGS == 16) ? 4 : 5;

    state_t      state, state_nxt;
    logic [31:0] pc, old_pc, instr, data, a, b, alu_out;
    logic [31:0] regs [NREGS];
    logic [31:0] rs1_val, rs2_val, alu_b, alu_y, rf_wdata;
    logic        rf_we, illegal, taken;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u  = {instr[31:12], 12'd0};
    assign taken  = ((a - b) == 32'd0) ^ f3[0];

    // Registers at or above NREGS behave like x0.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0 && {27'd0, rs1} < NREGS) rs1_val = regs[rs1[AW-1:0]];
        if (rs2 != 5'd0 && {27'd0, rs2} < NREGS) rs2_val = regs[rs2[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0 && {27'd0, rd} < NREGS) regs[rd[AW-1:0]] <= rf_wdata;
    end

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP_R, OP_I: illegal = !(f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
            OP_LW, OP_SW, OP_BR, OP_JAL, OP_LUI: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_b = (state == EXECI) ? imm_i : b;
        case (f3)
            3'b000:  alu_y = (state == EXECR && instr[30]) ? a - alu_b : a + alu_b;
            3'b010:  alu_y = {31'd0, $signed(a) < $signed(alu_b)};
            3'b110:  alu_y = a | alu_b;
            3'b111:  alu_y = a & alu_b;
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        MemReq    = 1'b0;
        MemWE     = 1'b0;
        MemAdr    = '0;
        MemWData  = '0;
        Retire    = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        case (state)
            FETCH: begin
                MemReq = 1'b1;
                MemAdr = {pc[31:2], 2'b00};
                if (MemReady) state_nxt = DECODE;
            end
            DECODE: begin
                if (illegal) begin
`ifdef RV_ILLEGAL_HALT_EN
                    state_nxt = HALT;
`else
                    Retire    = 1'b1;
                    state_nxt = FETCH;
`endif
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_nxt = MEMADR;
                        OP_R:         state_nxt = EXECR;
                        OP_I:         state_nxt = EXECI;
                        OP_BR:        state_nxt = BRANCH;
                        OP_JAL:       state_nxt = JAL;
                        OP_LUI:       state_nxt = LUI;
                        default:      state_nxt = FETCH;
                    endcase
                end
            end
            MEMADR: state_nxt = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                MemReq = 1'b1;
                MemAdr = alu_out;
                if (MemReady) state_nxt = MEMWB;
            end
            MEMWB: begin
                rf_we     = 1'b1;
                rf_wdata  = data;
                Retire    = 1'b1;
                state_nxt = FETCH;
            end
            MEMWRITE: begin
                MemReq   = 1'b1;
                MemWE    = 1'b1;
                MemAdr   = alu_out;
                MemWData = b;
                if (MemReady) begin
                    Retire    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            EXECR, EXECI: state_nxt = ALUWB;
            ALUWB: begin
                rf_we     = 1'b1;
                rf_wdata  = alu_out;
                Retire    = 1'b1;
                state_nxt = FETCH;
            end
            BRANCH: begin
                Retire    = 1'b1;
                state_nxt = FETCH;
            end
            JAL: begin
                rf_we     = 1'b1;
                rf_wdata  = pc;
                Retire    = 1'b1;
                state_nxt = FETCH;
            end
            LUI: begin
                rf_we     = 1'b1;
                rf_wdata  = imm_u;
                Retire    = 1'b1;
                state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
        // The FSM already sits in FETCH during reset; keep the port quiet as well.
        if (reset) begin
            MemReq   = 1'b0;
            MemWE    = 1'b0;
            MemAdr   = '0;
            MemWData = '0;
            Retire   = 1'b0;
        end
    end

`ifdef RV_ILLEGAL_HALT_EN
    assign Halted = (state == HALT) && !reset;
`else
    assign Halted = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            instr   <= '0;
            data    <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            case (state)
                FETCH: if (MemReady) begin
                    instr  <= MemRData;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                end
                DECODE: begin
                    a       <= rs1_val;
                    b       <= rs2_val;
                    alu_out <= old_pc + imm_b;
                end
                MEMADR:       alu_out <= a + ((opcode == OP_SW) ? imm_s : imm_i);
                MEMREAD:      if (MemReady) data <= MemRData;
                EXECR, EXECI: alu_out <= alu_y;
                BRANCH:       if (taken) pc <= alu_out;
                JAL:          pc <= old_pc + imm_j;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/riscv_multicycle.md
# riscv_multicycle

Parametrised multicycle RV32I-subset core: the successor to the single-cycle processor, sharing one unified instruction/data memory port with a req/ready handshake so slow or arbitrated memories can stall it. It sits where the single-cycle core sits in `top`, connecting directly to a unified memory, and adds `bne`, `lui`, a configurable register count and a configurable reset vector.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset.
- `NREGS`, default 32, architectural register count; legal values are 16 (RV32E-style) or 32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `MemReq`  out  1  memory access request; held until accepted.
- `MemWE`  out  1  write enable, valid while `MemReq`=1.
- `MemAdr`  out  32  byte address; word-aligned; bits [1:0] are always 0 for fetch.
- `MemWData`  out  32  store data, valid while `MemReq`&`MemWE`.
- `MemRData`  in  32  read data, valid in the cycle `MemReady`=1.
- `MemReady`  in  1  access completes in the cycle where `MemReq`&`MemReady`.
- `Retire`  out  1  one-cycle pulse in the final cycle of each instruction.
- `Halted`  out  1  core stopped on an illegal instruction (see Configuration).

## Operation
- Instruction set:
  - R-type: `add sub and or slt`.
  - I-type ALU: `addi andi ori slti`.
  - Memory: `lw sw`.
  - Control flow: `beq bne jal`.
  - Upper immediate: `lui`.
  - Encodings and ALU semantics match RV32I; `slt` is signed.
- Registers:
  - x0 reads 0 and writes to it are dropped.
  - With `NREGS`=16, accesses to x16–x31 read 0 and writes to them are dropped.
- Internal registers:
  - `PC`, `OldPC`, `Instr`, `Data` (load buffer), `A`, `B`, `ALUOut`.
  - All are cleared on reset, except `PC`, which is set to `RESET_PC`.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT.
- FETCH:
  - Drives `MemReq`=1, `MemWE`=0, `MemAdr`=PC.
  - On `MemReady`: `Instr`←`MemRData`, `OldPC`←PC, PC←PC+4, go to DECODE.
  - Otherwise stays in FETCH with outputs stable.
- DECODE:
  - Loads `A` and `B` from the register file.
  - Computes `ALUOut`←OldPC+B-type immediate (speculative branch target).
  - Dispatches by opcode:
    - lw/sw → MEMADR.
    - R-type → EXECR.
    - I-type ALU → EXECI.
    - beq/bne → BRANCH.
    - jal → JAL.
    - lui → LUI.
    - Any other opcode → illegal handling.
- MEMADR: `ALUOut`←A+imm (I-type immediate for lw, S-type for sw); go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: `MemReq`=1, `MemAdr`=`ALUOut`; on `MemReady`, `Data`←`MemRData` and go to MEMWB.
- MEMWB: rd←`Data`; `Retire`=1; go to FETCH.
- MEMWRITE: `MemReq`=1, `MemWE`=1, `MemAdr`=`ALUOut`, `MemWData`=B; on `MemReady`, `Retire`=1 and go to FETCH.
- EXECR / EXECI: `ALUOut`←A op B (EXECR) or A op imm (EXECI); go to ALUWB.
- ALUWB: rd←`ALUOut`; `Retire`=1; go to FETCH.
- BRANCH:
  - Compares A−B.
  - beq takes the branch when A−B is zero; bne takes it when nonzero.
  - If taken, PC←`ALUOut`.
  - `Retire`=1; go to FETCH.
- JAL: rd←PC (already PC+4); PC←OldPC+J-type immediate; `Retire`=1; go to FETCH.
- LUI: rd←{imm[31:12],12'b0}; `Retire`=1; go to FETCH.
- Arithmetic: all arithmetic is 32-bit, wraps modulo 2^32, and has no overflow detection.
- Misaligned addresses: low address bits are passed through unchanged; alignment is the memory's concern.

## Timing
- Latency with zero wait states (`MemReady` high whenever requested):
  - lw: 5 cycles.
  - sw, R-type, I-type ALU: 4 cycles.
  - beq, bne, jal, lui: 3 cycles.
- Each cycle with `MemReq`=1 and `MemReady`=0 adds one cycle to the instruction.
- Handshake rules:
  - Once `MemReq` rises, `MemReq`, `MemWE`, `MemAdr` and `MemWData` stay constant until the accepting cycle.
  - `MemReq` is 0 in every non-memory state.
  - `MemReady` is ignored whenever `MemReq`=0.
- Register-file writes and PC updates occur at the rising edge that ends the state.
- Reset values while `reset` is high:
  - `MemReq`, `MemWE`, `Retire` and `Halted` are 0.
  - `MemAdr` and `MemWData` are 0.
  - The FSM is in FETCH.
- The first request appears in the first cycle after `reset` deasserts, with `MemAdr`=`RESET_PC`.
- Reset asserted mid-access aborts the access immediately; there is no write completion obligation.

## Configuration
- `RV_ILLEGAL_HALT_EN` defined:
  - An unrecognised opcode, or an unsupported funct3 on R-type/I-type, sends DECODE to HALT.
  - In HALT: `Halted`=1, `MemReq`=0, no further retirement.
  - HALT is left only by reset.
- `RV_ILLEGAL_HALT_EN` not defined:
  - Illegal instructions execute as a NOP: DECODE → FETCH with `Retire`=1, taking 2 cycles.
  - `Halted` is tied to 0.

## Test plan
- Reset with `RESET_PC`=32'h100 and zero-wait memory → first `MemAdr`=32'h100 with `MemReq`=1 in the first post-reset cycle; x0 remains 0 after `addi x0,x0,5`.
- Program `addi x2,x0,5`; `addi x3,x0,12`; `sub x4,x3,x2`; `sw x4,84(x0)` → a write with `MemAdr`=84 and `MemWData`=7; `Retire` pulses spaced 4,4,4,4 cycles.
- `MemReady` held low for 3 cycles on every access during an `lw` → the `lw` retires in 5+3+3=11 cycles; `MemAdr` and `MemReq` are stable throughout each stall.
- `bne` with equal operands falls through; `bne` with unequal operands jumps −8; `beq` taken → PC sequence matches; branch `Retire` pulses are 3 cycles apart.
- `lui x5,0x12345`; `sw x5,0(x0)` → `MemWData`=32'h12345000. With `NREGS`=16, `addi x20,x0,9`; `sw x20,0(x0)` → `MemWData`=0.
- Opcode 7'b1111111 → with `RV_ILLEGAL_HALT_EN`, `Halted`=1 and `MemReq` stays 0 until reset; without it, a 2-cycle `Retire` and the next fetch at PC+4.
